ldpc_in_buf: RTL and testbench
==============================

# ldpc_in_buf

Ping-pong soft-bit frame buffer that sits directly upstream of the LDPC decoder. It collects 6-bit LLR samples from the demapper, which arrive with gaps and are marked by a valid strobe, into one of two 9216-entry banks. It then replays each complete codeword to the decoder as one gap-free burst with the decoder's sync qualifier held high. It protects the decoder from partial frames and never starts a burst while the decoder reports busy.

## Interface
- D_WID, 6, LLR sample width (matches decoder data_in)
- FRM_LEN, 9216, samples per codeword
- AW, 14, address width, ceil(log2(FRM_LEN))

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- llr_in  in  D_WID  soft sample from demapper
- llr_vld  in  1  llr_in valid this cycle
- frm_start  in  1  qualifies the first sample of a codeword; ignored unless llr_vld=1
- dec_busy  in  1  decoder busy flag
- data_out  out  D_WID  sample to decoder data_in; forced 0 when sync_out=0
- sync_out  out  1  to decoder sync_in; high for exactly FRM_LEN consecutive cycles per frame
- ovf  out  1  one-cycle pulse: incoming frame dropped, both banks full
- trunc  out  1  one-cycle pulse: frm_start arrived before the previous frame completed
- buf_full  out  2  per-bank full flags, bit0 = bank 0

## Operation
- Storage: two banks of FRM_LEN x D_WID, each a synchronous-read RAM with 1-cycle read latency. Per-bank full flag. wr_bank and rd_bank pointers start at 0 and toggle on bank completion or bank release.
- Write FSM states:
  - W_IDLE: on llr_vld&frm_start, if full[wr_bank]=0 (evaluated after any same-cycle release by the read side), write sample at addr 0, set wcnt=1, go to W_FILL. Otherwise pulse ovf and go to W_DROP.
  - W_FILL: each llr_vld writes at wcnt and increments wcnt. If the sample is at wcnt=FRM_LEN-1: set full[wr_bank], toggle wr_bank, go to W_IDLE.
  - W_FILL, llr_vld&frm_start before completion: pulse trunc, discard partial data, restart at addr 0 of the same bank with wcnt=1.
  - W_DROP: ignore samples until the next llr_vld&frm_start, then re-evaluate as in W_IDLE, in the same cycle.
  - In W_IDLE, llr_vld without frm_start is discarded.
- Read FSM states:
  - R_IDLE: if full[rd_bank]=1 and dec_busy=0, go to R_RUN with raddr=0.
  - R_RUN: raddr increments every cycle, with no stall. dec_busy is ignored once the burst has started. After raddr=FRM_LEN-1 is issued, clear full[rd_bank], toggle rd_bank, go to R_GAP.
  - R_GAP: wait 2 cycles so the decoder's busy can rise, then go to R_IDLE.
- Frames are delivered strictly in arrival order.
- Arithmetic: wcnt and raddr are AW-bit and never exceed FRM_LEN-1. There is no modulo wrap; the counters reset to 0 per frame.
- Reset: all FSMs idle, full=00, wr_bank=rd_bank=0, counters 0. Any partial frame or stored frames are lost. Outputs are low after reset and again within the same edge if reset is asserted mid-burst.

## Timing
- Reset values: data_out=0, sync_out=0, ovf=0, trunc=0, buf_full=00.
- Let edge T be the clock edge that captures the last sample of a frame into an idle buffer with dec_busy=0.
  - buf_full bit is high after edge T.
  - R_RUN is entered at edge T+1.
  - sync_out=1 and data_out=sample 0 are valid after edge T+2.
  - sync_out stays high through sample FRM_LEN-1, which is FRM_LEN cycles.
- Next burst start: minimum 2 idle cycles of sync_out between bursts, plus any time dec_busy is high.
- ovf and trunc are registered and high for exactly 1 cycle, following the edge on which the condition was detected.
- Simultaneous events:
  - The read side clearing full[b] on the same edge that a frame start targets bank b: the frame is accepted, not dropped.
  - Write completion and read start on the same bank on the same edge cannot occur, because a full bank is never written.

## Test plan
- Single frame, llr_vld=1 continuously, llr_in = addr mod 64, dec_busy=0 -> sync_out high 9216 cycles starting 2 cycles after the last write; data_out sequence 0..63 repeating; buf_full returns to 00.
- Gappy input (llr_vld toggling 1-0), two frames back to back, dec_busy held 1 for 20000 cycles -> buf_full=11, no sync_out; after dec_busy falls, two bursts each exactly 9216 long in arrival order, separated by at least 2 low cycles.
- Third frame started while buf_full=11 -> ovf single pulse; third frame's data never appears; a fourth frame starting after a bank frees is accepted.
- frm_start reasserted at sample 5000 -> trunc pulse; the delivered frame contains only the restarted data (samples from the second start), length 9216.
- dec_busy rises mid-burst -> burst continues uninterrupted for its full 9216 cycles; the next burst waits for dec_busy=0.
- Asynchronous reset at sample 3000 of an output burst -> sync_out and data_out are 0 immediately; buf_full=00; a new complete frame after release is delivered normally.

Source files
------------

// File: rtl/ldpc_in_buf.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_in_buf
// Brief    : Ping-pong LLR frame buffer; replays complete codewords to the
//            LDPC decoder as gap-free bursts qualified by sync_out.
// Revision : 1.0
// ============================================================================
module ldpc_in_buf #(
  parameter int D_WID   = 6,
  parameter int FRM_LEN = 9216,
  parameter int AW      = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [D_WID-1:0] llr_in,
  input  logic             llr_vld,
  input  logic             frm_start,
  input  logic             dec_busy,
  output logic [D_WID-1:0] data_out,
  output logic             sync_out,
  output logic             ovf,
  output logic             trunc,
  output logic [1:0]       buf_full
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RUN = 2'd1, R_GAP = 2'd2} rd_state_t;

  localparam logic [AW-1:0] C_LAST = AW'(FRM_LEN - 1);

  wr_state_t        wst_q, wst_d;
  rd_state_t        rst_q, rst_d;
  logic [AW-1:0]    wcnt_q, wcnt_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic             gap_q, gap_d;
  logic [1:0]       full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             trunc_q, trunc_d;
  logic             sync_q, rsel_q;
  logic [D_WID-1:0] rd0_q, rd1_q;

  logic [D_WID-1:0] bank0_q [FRM_LEN];
  logic [D_WID-1:0] bank1_q [FRM_LEN];

  logic             w_start, w_wr_ok, w_we, w_set_full, w_rel;
  logic [AW-1:0]    w_waddr;

  assign w_start = llr_vld & frm_start;

  // Read side: burst runs uninterrupted once started; dec_busy only gates entry.
  always_comb begin
    rst_d   = rst_q;
    raddr_d = raddr_q;
    rbank_d = rbank_q;
    gap_d   = gap_q;
    w_rel   = 1'b0;
    case (rst_q)
      R_IDLE: begin
        if (full_q[rbank_q] && !dec_busy) begin
          rst_d   = R_RUN;
          raddr_d = '0;
        end
      end
      R_RUN: begin
        if (raddr_q == C_LAST) begin
          w_rel   = 1'b1;
          rbank_d = ~rbank_q;
          raddr_d = '0;
          gap_d   = 1'b0;
          rst_d   = R_GAP;
        end else begin
          raddr_d = raddr_q + AW'(1);
        end
      end
      R_GAP: begin
        if (gap_q) begin
          gap_d = 1'b0;
          rst_d = R_IDLE;
        end else begin
          gap_d = 1'b1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  // A bank being released on this very edge counts as free for a new frame.
  assign w_wr_ok = ~full_q[wbank_q] | (w_rel & (rbank_q == wbank_q));

  always_comb begin
    wst_d      = wst_q;
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    w_we       = 1'b0;
    w_waddr    = wcnt_q;
    w_set_full = 1'b0;
    ovf_d      = 1'b0;
    trunc_d    = 1'b0;
    case (wst_q)
      W_IDLE, W_DROP: begin
        if (w_start) begin
          if (w_wr_ok) begin
            w_we    = 1'b1;
            w_waddr = '0;
            wcnt_d  = AW'(1);
            wst_d   = W_FILL;
          end else begin
            ovf_d = 1'b1;
            wst_d = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (w_start) begin
          trunc_d = 1'b1;
          w_we    = 1'b1;
          w_waddr = '0;
          wcnt_d  = AW'(1);
        end else if (llr_vld) begin
          w_we = 1'b1;
          if (wcnt_q == C_LAST) begin
            w_set_full = 1'b1;
            wbank_d    = ~wbank_q;
            wcnt_d     = '0;
            wst_d      = W_IDLE;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (w_rel)      full_d[rbank_q] = 1'b0;
    if (w_set_full) full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wst_q   <= W_IDLE;
      rst_q   <= R_IDLE;
      wcnt_q  <= '0;
      raddr_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      gap_q   <= 1'b0;
      full_q  <= 2'b00;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
      sync_q  <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      wst_q   <= wst_d;
      rst_q   <= rst_d;
      wcnt_q  <= wcnt_d;
      raddr_q <= raddr_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      gap_q   <= gap_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
      sync_q  <= (rst_q == R_RUN);
      rsel_q  <= rbank_q;
    end
  end

  // Storage arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we && !wbank_q) bank0_q[w_waddr] <= llr_in;
    if (w_we &&  wbank_q) bank1_q[w_waddr] <= llr_in;
    rd0_q <= bank0_q[raddr_q];
    rd1_q <= bank1_q[raddr_q];
  end

  assign data_out = sync_q ? (rsel_q ? rd1_q : rd0_q) : '0;
  assign sync_out = sync_q;
  assign ovf      = ovf_q;
  assign trunc    = trunc_q;
  assign buf_full = full_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_in_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ldpc_in_buf
// Brief    : Self-checking bench for ldpc_in_buf; frames modelled as a
//            two-deep FIFO of sample lists.
// Revision : 1.0
// ============================================================================
module tb_ldpc_in_buf;

  localparam int D_WID   = 6;
  localparam int FRM_LEN = 9216;
  localparam int AW      = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic [D_WID-1:0] llr_in;
  logic             llr_vld;
  logic             frm_start;
  logic             dec_busy;
  logic [D_WID-1:0] data_out;
  logic             sync_out;
  logic             ovf;
  logic             trunc;
  logic [1:0]       buf_full;

  ldpc_in_buf #(.D_WID(D_WID), .FRM_LEN(FRM_LEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .llr_in(llr_in), .llr_vld(llr_vld),
    .frm_start(frm_start), .dec_busy(dec_busy), .data_out(data_out),
    .sync_out(sync_out), .ovf(ovf), .trunc(trunc), .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: accepted frames queue up as expected output samples.
  logic [D_WID-1:0] tx_q[$];
  logic [D_WID-1:0] exp_data[$];
  int pending   = 0;
  int exp_ovf   = 0;
  int exp_trunc = 0;

  bit in_b = 1'b0;
  int cur_len = 0, cur_err = 0, cur_start = 0, last_cyc = 0;
  int blen[$], berr[$], bstart[$], bend[$];
  logic [1:0] bfull[$];
  int nb = 0, dz_err = 0;
  int ovf_cnt = 0, ovf_wide = 0, trunc_cnt = 0, trunc_wide = 0;
  bit ovf_prev = 1'b0, trunc_prev = 1'b0;
  logic [D_WID-1:0] mon_e;

  bit acc1, acc2, acc3, acc4, acc5, acc6;
  int t1, t6, busy_rise, t_fall, g;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gen_frame(input int n, input bit mod64);
    tx_q.delete();
    for (int i = 0; i < n; i++)
      tx_q.push_back(mod64 ? D_WID'(i % 64) : D_WID'($urandom_range(0, 63)));
  endtask

  task automatic begin_frame(output bit acc);
    acc = (pending < 2);
    if (!acc) exp_ovf++;
  endtask

  task automatic commit_frame();
    foreach (tx_q[i]) exp_data.push_back(tx_q[i]);
    pending++;
  endtask

  // gap_mod > 0 inserts idle cycles with probability 1/gap_mod before each sample.
  task automatic send_tx(input int gap_mod);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gap_mod > 0) begin
        while ($urandom_range(0, gap_mod - 1) == 0) begin
          llr_vld   = 1'b0;
          frm_start = 1'($urandom_range(0, 1));
          llr_in    = D_WID'($urandom_range(0, 63));
          tick();
        end
      end
      llr_vld   = 1'b1;
      frm_start = (i == 0);
      llr_in    = tx_q[i];
      tick();
    end
    llr_vld   = 1'b0;
    frm_start = 1'b0;
  endtask

  task automatic rec_burst();
    blen.push_back(cur_len);
    berr.push_back(cur_err);
    bstart.push_back(cur_start);
    bend.push_back(last_cyc);
    bfull.push_back(buf_full);
    nb++;
  endtask

  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      if (in_b) rec_burst();
      in_b       = 1'b0;
      ovf_prev   = 1'b0;
      trunc_prev = 1'b0;
    end else begin
      if (sync_out === 1'b1) begin
        if (!in_b) begin
          in_b      = 1'b1;
          cur_len   = 0;
          cur_err   = 0;
          cur_start = cyc;
        end
        if (exp_data.size() == 0) cur_err++;
        else begin
          mon_e = exp_data.pop_front();
          if (data_out !== mon_e) cur_err++;
        end
        cur_len++;
        last_cyc = cyc;
      end else begin
        if (in_b) begin
          rec_burst();
          in_b = 1'b0;
          if (pending > 0) pending--;
        end
        if (data_out !== '0) dz_err++;
      end
      if (ovf === 1'b1) begin
        if (ovf_prev) ovf_wide++; else ovf_cnt++;
      end
      if (trunc === 1'b1) begin
        if (trunc_prev) trunc_wide++; else trunc_cnt++;
      end
      ovf_prev   = (ovf === 1'b1);
      trunc_prev = (trunc === 1'b1);
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; llr_in = '0; llr_vld = 1'b0; frm_start = 1'b0; dec_busy = 1'b0;
    repeat (3) tick();
    check("rst_data_out", data_out, 0);
    check("rst_sync_out", sync_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_trunc", trunc, 0);
    check("rst_buf_full", buf_full, 0);
    reset = 1'b0;
    tick();

    // Frame 1: continuous, addr mod 64, decoder idle.
    gen_frame(FRM_LEN, 1'b1);
    begin_frame(acc1);
    send_tx(0);
    t1 = cyc;
    if (acc1) commit_frame();
    check("full_after_last_write", buf_full, 2'b01);

    // Frame 2 gappy, frame 3 truncated at 5000 then restarted; busy rises mid-burst 1.
    fork
      begin
        gen_frame(FRM_LEN, 1'b0);
        begin_frame(acc2);
        send_tx(4);
        if (acc2) commit_frame();
        gen_frame(5000, 1'b0);
        begin_frame(acc3);
        send_tx(0);
        exp_trunc++;
        gen_frame(FRM_LEN, 1'b0);
        send_tx(0);
        if (acc3) commit_frame();
      end
      begin
        repeat (100) tick();
        dec_busy  = 1'b1;
        busy_rise = cyc;
      end
    join
    tick();
    check("both_banks_full", buf_full, 2'b11);
    check("bursts_while_busy", nb, 1);
    check("trunc_pulses", trunc_cnt, exp_trunc);

    // Frame 4 arrives with both banks full and must be dropped.
    gen_frame(200, 1'b0);
    begin_frame(acc4);
    send_tx(0);
    if (acc4) commit_frame();
    repeat (3) tick();
    check("ovf_pulses", ovf_cnt, exp_ovf);
    check("no_burst_during_ovf", nb, 1);

    while (cyc - busy_rise < 20000) tick();
    dec_busy = 1'b0;
    t_fall   = cyc;

    g = 0;
    while (nb < 2 && g < 3 * FRM_LEN) begin tick(); g++; end
    check("wait_burst2_timeout", g < 3 * FRM_LEN, 1);

    // Frame 5 starts once a bank has been released.
    gen_frame(FRM_LEN, 1'b0);
    begin_frame(acc5);
    send_tx(0);
    if (acc5) commit_frame();

    g = 0;
    while (!(nb >= 3 && in_b && cur_len >= 3000) && g < 4 * FRM_LEN) begin tick(); g++; end
    check("wait_burst4_timeout", g < 4 * FRM_LEN, 1);

    reset = 1'b1;
    #1;
    check("midburst_rst_sync", sync_out, 0);
    check("midburst_rst_data", data_out, 0);
    check("midburst_rst_full", buf_full, 0);
    tick();
    tick();
    reset = 1'b0;
    exp_data.delete();
    pending = 0;
    tick();

    // Frame 6 after reset release.
    gen_frame(FRM_LEN, 1'b0);
    begin_frame(acc6);
    send_tx(0);
    t6 = cyc;
    if (acc6) commit_frame();

    g = 0;
    while (nb < 5 && g < 3 * FRM_LEN) begin tick(); g++; end
    check("wait_burst6_timeout", g < 3 * FRM_LEN, 1);
    tick();

    check("burst_count", nb, 5);
    if (nb >= 5) begin
      check("b1_len", blen[0], FRM_LEN);
      check("b1_data_errs", berr[0], 0);
      check("b1_latency", bstart[0] - t1, 2);
      check("b1_full_after", bfull[0], 2'b00);
      check("busy_rose_mid_b1", (busy_rise > bstart[0]) && (busy_rise < bend[0]), 1);
      check("b2_len", blen[1], FRM_LEN);
      check("b2_data_errs", berr[1], 0);
      check("b2_after_busy_fall", bstart[1] > t_fall, 1);
      check("b3_len", blen[2], FRM_LEN);
      check("b3_data_errs", berr[2], 0);
      check("gap_b2_b3_min2", (bstart[2] - bend[1]) >= 3, 1);
      check("b4_cut_short", (blen[3] >= 3000) && (blen[3] < FRM_LEN), 1);
      check("b4_data_errs", berr[3], 0);
      check("b5_len", blen[4], FRM_LEN);
      check("b5_data_errs", berr[4], 0);
      check("b5_latency", bstart[4] - t6, 2);
    end
    check("final_buf_full", buf_full, 2'b00);
    check("data_nonzero_sync_low", dz_err, 0);
    check("ovf_total", ovf_cnt, exp_ovf);
    check("ovf_wide", ovf_wide, 0);
    check("trunc_total", trunc_cnt, exp_trunc);
    check("trunc_wide", trunc_wide, 0);
    check("expected_left", exp_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
